// File: rtl/mem_access_unit.sv
// mem_access_unit: accepts writeback commands, runs the data-memory bus handshake
// for loads/stores, and returns one registered result pulse per command.
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  write_r,
    input  logic        write_en,
    input  logic [31:0] write_data,
    input  logic        read_mm,
    input  logic        write_mm,
    input  logic [31:0] mm_addr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_r,
    output logic        wb_en,
    output logic [31:0] wb_data,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       r_q;
    logic             en_q;
    logic             mem_op;
    logic             bad;
    logic             timeout;
    assign mem_op  = read_mm | write_mm;
    assign bad     = (read_mm & write_mm) | (mem_op & (mm_addr[1:0] != 2'b00));
    // Last allowed bus cycle: the counter would reach TIMEOUT-1 on this edge.
    assign timeout = cnt_q == CNT_W'(TIMEOUT - 2);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            r_q       <= '0;
            en_q      <= 1'b0;
            in_ready  <= 1'b1;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_r      <= '0;
            wb_en     <= 1'b0;
            wb_data   <= '0;
            err       <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            err      <= 1'b0;
            case (state_q)
                IDLE: if (in_valid) begin
                    in_ready <= 1'b0;
                    r_q      <= write_r;
                    en_q     <= write_en;
                    if (!mem_op || bad) begin
                        state_q  <= DONE;
                        wb_valid <= 1'b1;
                        wb_r     <= write_r;
                        wb_en    <= write_en & ~mem_op;
                        wb_data  <= write_data;
                        err      <= bad;
                    end else begin
                        state_q   <= REQ;
                        cnt_q     <= '0;
                        bus_req   <= 1'b1;
                        bus_we    <= write_mm;
                        bus_addr  <= mm_addr;
                        bus_wdata <= write_data;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus_gnt && bus_we) begin
                        state_q  <= DONE;
                        bus_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_r     <= r_q;
                        wb_en    <= 1'b0;
                        wb_data  <= bus_wdata;
                    end else if (timeout) begin
                        state_q  <= DONE;
                        bus_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_r     <= r_q;
                        wb_en    <= 1'b0;
                        err      <= 1'b1;
                    end else if (bus_gnt) begin
                        state_q <= WAIT_R;
                        bus_req <= 1'b0;
                    end
                end
                WAIT_R: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus_rvalid) begin
                        state_q  <= DONE;
                        wb_valid <= 1'b1;
                        wb_r     <= r_q;
                        wb_en    <= en_q;
                        wb_data  <= bus_rdata;
                    end else if (timeout) begin
                        state_q  <= DONE;
                        wb_valid <= 1'b1;
                        wb_r     <= r_q;
                        wb_en    <= 1'b0;
                        err      <= 1'b1;
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    in_ready <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
